// File: rtl/phys_free_list.sv
// Circular free list of physical register tags with speculative and retirement heads.
// Optional FREELIST_WATERMARK_EN adds free_cnt_o / low_water_o observability outputs.
module phys_free_list #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int ARCH_REGS      = 64,
  parameter int PHYS_REGS      = 128
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [DISPATCH_WIDTH-1:0]                     alloc_req_i,
  output logic                                          alloc_ready_o,
  output logic [DISPATCH_WIDTH-1:0][$clog2(PHYS_REGS)-1:0] alloc_prf_o,
  input  logic [COMMIT_WIDTH-1:0]                       commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0]                       commit_rd_wen_i,
  input  logic [COMMIT_WIDTH-1:0][$clog2(PHYS_REGS)-1:0] commit_old_prf_i,
  input  logic                                          flush_i,
  output logic                                          empty_o
`ifdef FREELIST_WATERMARK_EN
  ,
  output logic [$clog2(PHYS_REGS-ARCH_REGS):0]          free_cnt_o,
  output logic [$clog2(PHYS_REGS-ARCH_REGS):0]          low_water_o
`endif
);

  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int IW = $clog2(FL_DEPTH);
  localparam int PW = IW + 1;
  localparam int TW = $clog2(PHYS_REGS);

  logic [TW-1:0] r_list [FL_DEPTH];
  logic [PW-1:0] r_spec_head;
  logic [PW-1:0] r_rtr_head;
  logic [PW-1:0] r_tail;

  logic [PW-1:0] w_free_cnt;
  logic [PW-1:0] w_acnt;
  logic [PW-1:0] w_ccnt;
  logic [DISPATCH_WIDTH-1:0][PW-1:0] w_aoff;
  logic [COMMIT_WIDTH-1:0][PW-1:0]   w_coff;
  logic [COMMIT_WIDTH-1:0][IW-1:0]   w_widx;
  logic [COMMIT_WIDTH-1:0]           w_fire;
  logic [PW-1:0] w_spec_n;
  logic [PW-1:0] w_rtr_n;
  logic [PW-1:0] w_tail_n;

  assign w_free_cnt    = r_tail - r_spec_head;
  assign alloc_ready_o = (w_free_cnt >= PW'(DISPATCH_WIDTH));
  assign empty_o       = (w_free_cnt == '0);

  // Requesting slots are compacted; idle slots show the in-order tag.
  always_comb begin
    w_acnt = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      w_aoff[i] = alloc_req_i[i] ? w_acnt : PW'(i);
      if (alloc_req_i[i]) w_acnt = w_acnt + PW'(1);
      alloc_prf_o[i] = r_list[IW'(r_spec_head + w_aoff[i])];
    end
  end

  always_comb begin
    w_ccnt = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      w_fire[j] = commit_valid_i[j] & commit_rd_wen_i[j];
      w_coff[j] = w_ccnt;
      w_widx[j] = IW'(r_tail + w_coff[j]);
      if (w_fire[j]) w_ccnt = w_ccnt + PW'(1);
    end
  end

  always_comb begin
    w_tail_n = r_tail + w_ccnt;
    w_rtr_n  = r_rtr_head + w_ccnt;
    w_spec_n = r_spec_head;
    if (flush_i)            w_spec_n = w_rtr_n;
    else if (alloc_ready_o) w_spec_n = r_spec_head + w_acnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FL_DEPTH; k++) r_list[k] <= TW'(ARCH_REGS + k);
      r_spec_head <= '0;
      r_rtr_head  <= '0;
      r_tail      <= PW'(FL_DEPTH);
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++)
        if (w_fire[j]) r_list[w_widx[j]] <= commit_old_prf_i[j];
      r_spec_head <= w_spec_n;
      r_rtr_head  <= w_rtr_n;
      r_tail      <= w_tail_n;
    end
  end

`ifdef FREELIST_WATERMARK_EN
  logic [PW-1:0] r_low_water;
  logic [PW-1:0] w_cnt_n;

  assign w_cnt_n     = w_tail_n - w_spec_n;
  assign free_cnt_o  = w_free_cnt;
  assign low_water_o = r_low_water;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_low_water <= PW'(FL_DEPTH);
    else if (w_cnt_n < r_low_water) r_low_water <= w_cnt_n;
  end
`endif

endmodule
